// File: rtl/bin2ascii_multi_if.sv
// Handshake and data bundle for bin2ascii_multi: the requester side drives start/chan_sel/data_in,
// the converter side returns the ASCII result with busy/valid_out/overflow.
interface bin2ascii_multi_if #(
  parameter int CHANNELS = 4,
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                         start;
  logic [SEL_W-1:0]             chan_sel;
  logic [CHANNELS*IN_WIDTH-1:0] data_in;
  logic [DIGITS*8-1:0]          ascii_out;
  logic                         busy;
  logic                         valid_out;
  logic                         overflow;

  modport master (
    output start, chan_sel, data_in,
    input  ascii_out, busy, valid_out, overflow
  );

  modport slave (
    input  start, chan_sel, data_in,
    output ascii_out, busy, valid_out, overflow
  );
endinterface

// File: rtl/bin2ascii_multi.sv
// Multi-channel binary to decimal ASCII converter using one double-dabble step per clock.
// Define BIN2ASCII_LZB_EN to blank leading zero digits with spaces.
module bin2ascii_multi #(
  parameter int CHANNELS = 4,
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
) (
  input  logic             clock,
  input  logic             reset,
  bin2ascii_multi_if.slave bus
);
  localparam int          BCD_W = 4 * DIGITS;
  localparam int          CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic [DIGITS*8-1:0] ascii_q, ascii_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;
  logic [IN_WIDTH-1:0] sel_value;
  logic [BCD_W-1:0]    bcd_adj;
  logic                accept;

  assign accept = bus.start && (state_q != CONV);

  // Out-of-range channel indices fall through to channel 0.
  always_comb begin
    sel_value = bus.data_in[IN_WIDTH-1:0];
    for (int k = 1; k < CHANNELS; k++) begin
      if (int'(bus.chan_sel) == k) sel_value = bus.data_in[k*IN_WIDTH +: IN_WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = accept ? CONV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    ascii_d    = ascii_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end

    if (state_q == DONE) begin
      valid_d    = 1'b1;
      overflow_d = ovf_flag_q;
      if (ovf_flag_q) begin
        ascii_d = {DIGITS{8'h2D}};
      end else begin
`ifdef BIN2ASCII_LZB_EN
        // Blank from the top digit down until the first nonzero digit; digit 0 always shows.
        logic lead;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
          if ((bcd_q[4*i +: 4] != 4'd0) || (i == 0)) lead = 1'b0;
          ascii_d[8*i +: 8] = lead ? 8'h20 : {4'h3, bcd_q[4*i +: 4]};
        end
`else
        for (int i = 0; i < DIGITS; i++) begin
          ascii_d[8*i +: 8] = {4'h3, bcd_q[4*i +: 4]};
        end
`endif
      end
    end

    // The top adjusted bit is dropped; overflow is already known from the latched value.
    if (state_q == CONV) begin
      bcd_d   = BCD_W'({bcd_adj, shift_q[IN_WIDTH-1]});
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - CNT_W'(1);
    end

    if (accept) begin
      shift_d    = sel_value;
      bcd_d      = '0;
      cnt_d      = CNT_W'(IN_WIDTH);
      ovf_flag_d = (64'(sel_value) >= LIMIT);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      ascii_q    <= {DIGITS{8'h20}};
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      ascii_q    <= ascii_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.ascii_out = ascii_q;
  assign bus.valid_out = valid_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_bin2ascii_multi.sv
// Directed self-checking bench for bin2ascii_multi at default parameters.
// Expected ASCII patterns follow BIN2ASCII_LZB_EN when it is defined for the build.
module tb_bin2ascii_multi;
  localparam int CHANNELS = 4;
  localparam int IN_WIDTH = 14;
  localparam int DIGITS   = 4;

`ifdef BIN2ASCII_LZB_EN
  localparam logic [31:0] EXP_920 = 32'h20393230;
  localparam logic [31:0] EXP_0   = 32'h20202030;
  localparam logic [31:0] EXP_69  = 32'h20203639;
`else
  localparam logic [31:0] EXP_920 = 32'h30393230;
  localparam logic [31:0] EXP_0   = 32'h30303030;
  localparam logic [31:0] EXP_69  = 32'h30303639;
`endif
  localparam logic [31:0] EXP_4321  = 32'h34333231;
  localparam logic [31:0] EXP_OVF   = 32'h2D2D2D2D;
  localparam logic [31:0] EXP_SPACE = 32'h20202020;

  logic clock;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc;
  int   bad;

  bin2ascii_multi_if #(.CHANNELS(CHANNELS), .IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) bus ();

  bin2ascii_multi #(.CHANNELS(CHANNELS), .IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [1:0] sel, input int ch, input logic [IN_WIDTH-1:0] value);
    bus.start    = st;
    bus.chan_sel = sel;
    bus.data_in[ch*IN_WIDTH +: IN_WIDTH] = value;
  endtask

  // Counts edges until valid_out is seen, giving up after 40.
  task automatic waitValid(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!bus.valid_out && cycles < 40);
    if (!bus.valid_out) checkOutput("valid_timeout", 64'(bus.valid_out), 64'd1);
  endtask

  task automatic countValids(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.valid_out) seen++;
    end
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.chan_sel = '0;
    bus.data_in  = '0;
    repeat (3) tick();
    checkOutput("rst_ascii", 64'(bus.ascii_out), 64'(EXP_SPACE));
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_valid", 64'(bus.valid_out), 64'd0);
    checkOutput("rst_ovf", 64'(bus.overflow), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // 920 on channel 0 with full cycle-by-cycle timing.
    applyStimulus(1'b1, 2'd0, 0, 14'd920);
    bus.data_in[1*IN_WIDTH +: IN_WIDTH] = 14'd1234;
    tick();
    checkOutput("t1_busy_N", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    bad = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (!bus.busy || bus.valid_out) bad++;
    end
    checkOutput("t1_busy_window", 64'(bad), 64'd0);
    tick();
    checkOutput("t1_valid", 64'(bus.valid_out), 64'd1);
    checkOutput("t1_busy_end", 64'(bus.busy), 64'd0);
    checkOutput("t1_ascii", 64'(bus.ascii_out), 64'(EXP_920));
    checkOutput("t1_ovf", 64'(bus.overflow), 64'd0);
    tick();
    checkOutput("t1_valid_pulse", 64'(bus.valid_out), 64'd0);
    checkOutput("t1_ascii_hold", 64'(bus.ascii_out), 64'(EXP_920));

    // Zero on channel 2.
    applyStimulus(1'b1, 2'd2, 2, 14'd0);
    tick();
    bus.start = 1'b0;
    waitValid(cyc);
    checkOutput("t2_latency", 64'(cyc), 64'd15);
    checkOutput("t2_ascii", 64'(bus.ascii_out), 64'(EXP_0));
    checkOutput("t2_ovf", 64'(bus.overflow), 64'd0);

    // 10000 on channel 1 overflows four digits.
    applyStimulus(1'b1, 2'd1, 1, 14'd10000);
    tick();
    bus.start = 1'b0;
    waitValid(cyc);
    checkOutput("t3_latency", 64'(cyc), 64'd15);
    checkOutput("t3_ascii", 64'(bus.ascii_out), 64'(EXP_OVF));
    checkOutput("t3_ovf", 64'(bus.overflow), 64'd1);
    tick();
    checkOutput("t3_ovf_hold", 64'(bus.overflow), 64'd1);

    // Reset 7 cycles into a conversion.
    applyStimulus(1'b1, 2'd0, 0, 14'd920);
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    reset = 1'b0;
    #1;
    checkOutput("t6_ascii", 64'(bus.ascii_out), 64'(EXP_SPACE));
    checkOutput("t6_busy", 64'(bus.busy), 64'd0);
    checkOutput("t6_ovf", 64'(bus.overflow), 64'd0);
    checkOutput("t6_valid", 64'(bus.valid_out), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    countValids(25, cyc);
    checkOutput("t6_no_valid", 64'(cyc), 64'd0);

    // Second start during CONV is ignored; input changes do not disturb the result.
    applyStimulus(1'b1, 2'd3, 3, 14'd4321);
    tick();
    bus.start    = 1'b0;
    bus.chan_sel = 2'd1;
    bus.data_in[3*IN_WIDTH +: IN_WIDTH] = 14'd7;
    repeat (4) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    waitValid(cyc);
    checkOutput("t4_latency", 64'(cyc), 64'd10);
    checkOutput("t4_ascii", 64'(bus.ascii_out), 64'(EXP_4321));
    countValids(30, cyc);
    checkOutput("t4_single_valid", 64'(cyc), 64'd0);
    checkOutput("t4_idle", 64'(bus.busy), 64'd0);

    // Start held high: back-to-back conversions of 69.
    applyStimulus(1'b1, 2'd0, 0, 14'd69);
    tick();
    checkOutput("t5_busy", 64'(bus.busy), 64'd1);
    for (int r = 0; r < 3; r++) begin
      waitValid(cyc);
      checkOutput("t5_period", 64'(cyc), 64'd15);
      checkOutput("t5_ascii", 64'(bus.ascii_out), 64'(EXP_69));
      checkOutput("t5_busy_b2b", 64'(bus.busy), 64'd1);
    end
    bus.start = 1'b0;
    waitValid(cyc);
    checkOutput("t5_last_period", 64'(cyc), 64'd15);
    tick();
    checkOutput("t5_idle", 64'(bus.busy), 64'd0);

    // Start held through reset is taken on the first edge after release.
    reset = 1'b0;
    applyStimulus(1'b1, 2'd0, 0, 14'd920);
    repeat (2) tick();
    checkOutput("t7_busy_in_reset", 64'(bus.busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    checkOutput("t7_busy_first_edge", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    waitValid(cyc);
    checkOutput("t7_latency", 64'(cyc), 64'd15);
    checkOutput("t7_ascii", 64'(bus.ascii_out), 64'(EXP_920));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
